spi_flash_resp: RTL and testbench

SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

---
 rtl/spi_flash_resp.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_flash_resp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_resp.sv
// spi_flash_resp -- SPI (mode 0) slave that answers a single-opcode read
// command by fetching DATA_BYTES bytes from a backing store and shifting
// them back out MSB first.
//
// Transaction: ss_n low, 8-bit opcode, 24-bit address, then data. The
// fetch is issued as soon as the last address bit is sampled and must
// return before the first data-phase sck fall, otherwise the word is sent
// as zeros and the sticky underrun flag is set.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   spi_sck/ss_n/mosi     SPI inputs from the master (synchronized here)
//   spi_miso              SPI serial output
//   rd_req/rd_addr        backing-store request, held until rd_ack
//   rd_ack/rd_data        one-cycle data strobe and read word
//   busy                  transaction in progress
//   underrun              sticky: data was not ready in time
//
// Build option: define SPI_FLASH_RESP_AUTOINC_EN to keep fetching
// consecutive words (address += DATA_BYTES) while ss_n stays low. Without
// it, one word is sent and miso then drives 0 until ss_n rises.
module spi_flash_resp #(
  parameter int         DATA_BYTES  = 4,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    spi_sck,
  input  logic                    spi_ss_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    rd_req,
  output logic [23:0]             rd_addr,
  input  logic                    rd_ack,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    busy,
  output logic                    underrun
);

  localparam int NB = 8 * DATA_BYTES;
  localparam int CW = (NB > 24) ? $clog2(NB) + 1 : 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_FETCH  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  logic [SYNC_STAGES-1:0] sck_s_q, ss_s_q, mosi_s_q;
  logic                   sck_p_q, ss_p_q;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   in_q, in_d;
  logic [NB-1:0] shift_q, shift_d;
  logic          miso_q, miso_d;
  logic          rd_req_q, rd_req_d;
  logic [23:0]   rd_addr_q, rd_addr_d;
  logic          under_q, under_d;
  logic          disc_q, disc_d;   // outstanding request whose data is dropped
  logic          want_q, want_d;   // request queued behind an outstanding one
  logic          f0_q, f0_d;       // next fall only presents the MSB

  logic        sck_s, ss_s, mosi_s;
  logic        sck_rise, sck_fall, ss_rise, ss_fall, ack_ok;
  logic [23:0] addr_nxt, addr_inc;

  // Edges are taken between the synchronizer output and its previous value,
  // so mosi (same depth) is aligned with the detected sck rise.
  assign sck_s    = sck_s_q[SYNC_STAGES-1];
  assign ss_s     = ss_s_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_s_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_p_q;
  assign sck_fall = ~sck_s & sck_p_q;
  assign ss_rise  = ss_s & ~ss_p_q;
  assign ss_fall  = ~ss_s & ss_p_q;
  assign ack_ok   = rd_ack & rd_req_q;
  assign addr_nxt = {in_q[22:0], mosi_s};
  assign addr_inc = rd_addr_q + 24'(DATA_BYTES);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_d      = in_q;
    shift_d   = shift_q;
    miso_d    = miso_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    under_d   = under_q;
    disc_d    = disc_q;
    want_d    = want_q;
    f0_d      = f0_q;

    if (ack_ok) begin
      rd_req_d = 1'b0;
      disc_d   = 1'b0;
    end

    // A queued request goes out once the previous one has been acknowledged.
    if (want_q && !rd_req_q && !ss_rise) begin
      rd_req_d  = 1'b1;
      rd_addr_d = in_q;
      want_d    = 1'b0;
    end

    if (ss_rise) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      want_d  = 1'b0;
      if (rd_req_q && !rd_ack) disc_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ss_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            in_d  = addr_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(7)) begin
              cnt_d   = '0;
              state_d = (addr_nxt[7:0] == CMD_READ) ? S_ADDR : S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            in_d  = addr_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(23)) begin
              state_d = S_FETCH;
              cnt_d   = '0;
              f0_d    = 1'b1;
              if (!rd_req_q) begin
                rd_req_d  = 1'b1;
                rd_addr_d = addr_nxt;
              end else begin
                want_d = 1'b1;
              end
            end
          end
        end
        S_FETCH: begin
          if (ack_ok && !disc_q) begin
            shift_d = rd_data;
            miso_d  = rd_data[NB-1];
            state_d = S_DATA;
          end else if (sck_fall) begin
            // Data is late: send this word as zeros and drop the fetch.
            under_d = 1'b1;
            shift_d = '0;
            miso_d  = 1'b0;
            state_d = S_DATA;
            cnt_d   = f0_q ? CW'(0) : CW'(1);
            f0_d    = 1'b0;
            want_d  = 1'b0;
            if (rd_req_q && !rd_ack) disc_d = 1'b1;
          end
        end
        S_DATA: begin
          if (sck_fall) begin
            if (f0_q) begin
              f0_d = 1'b0;
            end else if (cnt_q == CW'(NB - 1)) begin
`ifdef SPI_FLASH_RESP_AUTOINC_EN
              // The word-ending fall also presents the next word's MSB.
              state_d = S_FETCH;
              cnt_d   = '0;
              miso_d  = 1'b0;
              in_d    = addr_inc;
              if (!rd_req_q) begin
                rd_req_d  = 1'b1;
                rd_addr_d = addr_inc;
              end else begin
                want_d = 1'b1;
              end
`else
              state_d = S_IGNORE;
              miso_d  = 1'b0;
`endif
            end else begin
              shift_d = shift_q << 1;
              miso_d  = shift_q[NB-2];
              cnt_d   = cnt_q + CW'(1);
            end
          end
        end
        S_IGNORE: miso_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_s_q   <= '0;
      ss_s_q    <= '1;
      mosi_s_q  <= '0;
      sck_p_q   <= 1'b0;
      ss_p_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      in_q      <= '0;
      shift_q   <= '0;
      miso_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      under_q   <= 1'b0;
      disc_q    <= 1'b0;
      want_q    <= 1'b0;
      f0_q      <= 1'b0;
    end else begin
      sck_s_q   <= {sck_s_q[SYNC_STAGES-2:0], spi_sck};
      ss_s_q    <= {ss_s_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_s_q  <= {mosi_s_q[SYNC_STAGES-2:0], spi_mosi};
      sck_p_q   <= sck_s;
      ss_p_q    <= ss_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_q      <= in_d;
      shift_q   <= shift_d;
      miso_q    <= miso_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      under_q   <= under_d;
      disc_q    <= disc_d;
      want_q    <= want_d;
      f0_q      <= f0_d;
    end
  end

  assign spi_miso = miso_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign underrun = under_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: an SPI mode-0 master driven from the
// main initial block, and a backing-store responder that acknowledges each
// rd_req after a programmable delay. Expected values are hand-computed.
module tb_spi_flash_resp;

  localparam int H = 8;  // sck half period in system clocks

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        busy;
  logic        underrun;

  int          total = 0;
  int          bad = 0;
  int          ack_dly = 2;
  int          req_cnt = 0;
  int          base_cnt = 0;
  logic [23:0] addr_log [0:7];
  logic [31:0] resp_word = 32'h0;
  logic [31:0] resp_next = 32'h0;

  logic [63:0] rx;
  logic        any1;
  int          base;

  always #5 clock = ~clock;

  spi_flash_resp dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .busy     (busy),
    .underrun (underrun)
  );

  // Backing store: ack is sampled by the DUT ack_dly cycles after rd_req.
  initial begin
    rd_ack  = 1'b0;
    rd_data = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (rd_req === 1'b1 && reset === 1'b0) begin
        addr_log[req_cnt % 8] = rd_addr;
        rd_data = (req_cnt == base_cnt) ? resp_word : resp_next;
        req_cnt++;
        repeat (ack_dly - 1) @(posedge clock);
        #1 rd_ack = 1'b1;
        @(posedge clock); #1;
        rd_ack = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sck_cycle(input logic mo, output logic mi);
    spi_mosi = mo;
    wait_clk(H);
    mi = spi_miso;
    spi_sck = 1'b1;
    wait_clk(H);
    spi_sck = 1'b0;
  endtask

  task automatic txn_open(input logic [31:0] hdr, input int nhdr, input int ndata,
                          output logic [63:0] rxo, output logic a1);
    logic mi;
    rxo = '0;
    a1  = 1'b0;
    spi_ss_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nhdr; i++) begin
      sck_cycle(hdr[31-i], mi);
      a1 = a1 | mi;
    end
    for (int i = 0; i < ndata; i++) begin
      sck_cycle(1'b0, mi);
      a1  = a1 | mi;
      rxo = {rxo[62:0], mi};
    end
  endtask

  task automatic txn_close();
    spi_mosi = 1'b0;
    wait_clk(H);
    spi_ss_n = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
    total++; if (rd_addr !== 24'h0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=000000", rd_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic do_read(input logic [23:0] a, input logic [31:0] d, input string nm);
    ack_dly = 2; resp_word = d; resp_next = d;
    base = req_cnt; base_cnt = req_cnt;
    txn_open({8'h03, a}, 32, 32, rx, any1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b exp=1", nm, busy); end
    txn_close();
    total++; if (rx[31:0] !== d) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, rx[31:0], d); end
    total++; if (req_cnt - base !== 1) begin bad++; $display("FAIL %s_nreq got=%0d exp=1", nm, req_cnt - base); end
    total++; if (addr_log[base % 8] !== a) begin bad++; $display("FAIL %s_addr got=%h exp=%h", nm, addr_log[base % 8], a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle got=%b exp=0", nm, busy); end
  endtask

  task automatic test_read();
    do_read(24'h000100, 32'hDEADBEEF, "read");
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL read_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_bad_opcode();
    base = req_cnt;
    txn_open({8'h0B, 24'h000100}, 32, 32, rx, any1);
    spi_mosi = 1'b0;
    wait_clk(H);
    spi_ss_n = 1'b1;
    wait_clk(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL badop_busy_before got=%b exp=1", busy); end
    wait_clk(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badop_busy_after got=%b exp=0", busy); end
    wait_clk(H);
    total++; if (any1 !== 1'b0) begin bad++; $display("FAIL badop_miso got=%b exp=0", any1); end
    total++; if (req_cnt - base !== 0) begin bad++; $display("FAIL badop_nreq got=%0d exp=0", req_cnt - base); end
  endtask

  task automatic test_abort();
    base = req_cnt;
    txn_open({8'h03, 24'hABCDEF}, 20, 0, rx, any1);
    txn_close();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL abort_rd_req got=%b exp=0", rd_req); end
    total++; if (req_cnt - base !== 0) begin bad++; $display("FAIL abort_nreq got=%0d exp=0", req_cnt - base); end
    do_read(24'hABCDEF, 32'h12345678, "after_abort");
  endtask

  task automatic test_underrun();
    ack_dly = 30; resp_word = 32'hA5A5A5A5; resp_next = 32'hA5A5A5A5;
    base_cnt = req_cnt;
    txn_open({8'h03, 24'h000200}, 32, 32, rx, any1);
    txn_close();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_flag got=%b exp=1", underrun); end
    total++; if (rx[31:0] !== 32'h0) begin bad++; $display("FAIL underrun_data got=%h exp=00000000", rx[31:0]); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL underrun_req_drop got=%b exp=0", rd_req); end
    do_read(24'h000300, 32'hDEADBEEF, "post_underrun");
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
  endtask

  task automatic test_wrap();
    ack_dly = 2; resp_word = 32'hCAFEF00D; resp_next = 32'h0BADC0DE;
    base = req_cnt; base_cnt = req_cnt;
    txn_open({8'h03, 24'hFFFFFC}, 32, 64, rx, any1);
    txn_close();
    total++; if (addr_log[base % 8] !== 24'hFFFFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffc", addr_log[base % 8]); end
    total++; if (rx[63:32] !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_word0 got=%h exp=cafef00d", rx[63:32]); end
`ifdef SPI_FLASH_RESP_AUTOINC_EN
    total++; if (req_cnt - base !== 2) begin bad++; $display("FAIL wrap_nreq got=%0d exp=2", req_cnt - base); end
    total++; if (addr_log[(base + 1) % 8] !== 24'h000000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=000000", addr_log[(base + 1) % 8]); end
    total++; if (rx[31:0] !== 32'h0BADC0DE) begin bad++; $display("FAIL wrap_word1 got=%h exp=0badc0de", rx[31:0]); end
`else
    total++; if (req_cnt - base !== 1) begin bad++; $display("FAIL wrap_nreq got=%0d exp=1", req_cnt - base); end
    total++; if (rx[31:0] !== 32'h0) begin bad++; $display("FAIL wrap_word1 got=%h exp=00000000", rx[31:0]); end
`endif
  endtask

  task automatic test_reset_mid_data();
    ack_dly = 2; resp_word = 32'hDEADBEEF; resp_next = 32'hDEADBEEF;
    base_cnt = req_cnt;
    txn_open({8'h03, 24'h000100}, 32, 4, rx, any1);
    wait_clk(5);
    total++; if (rx[3:0] !== 4'hD) begin bad++; $display("FAIL midrst_prefix got=%h exp=d", rx[3:0]); end
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL midrst_miso_pre got=%b exp=1", spi_miso); end
    #3 reset = 1'b1;
    #1;
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b exp=0", spi_miso); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL midrst_rd_req got=%b exp=0", rd_req); end
    total++; if (rd_addr !== 24'h0) begin bad++; $display("FAIL midrst_rd_addr got=%h exp=000000", rd_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL midrst_underrun got=%b exp=0", underrun); end
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    test_reset();
    test_read();
    test_bad_opcode();
    test_abort();
    test_underrun();
    test_wrap();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
